// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and strobe sequencer for an external 16-bit asynchronous SRAM.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN replaces fixed port-0 priority with round-robin arbitration.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 18
) (
  input  logic              clk_sys,
  input  logic              rst_,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [15:0]       ram_dout,
  output logic              ram_doe,
  input  logic [15:0]       ram_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              grant_r;
  logic              wr_r;
  logic              pick_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [15:0]       sel_wdata_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic              last_r;

  // Winner on contention is the port that was not served last
  always_comb begin
    pick_s = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Last-served pointer, refreshed while the access completes
  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      last_r <= 1'b1;
    end else if (state_r == HOLD) begin
      last_r <= grant_r;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests
  always_comb begin
    pick_s = 1'b0;
    if (req0) begin
      pick_s = 1'b0;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end
`endif

  // Request fields of the selected port
  always_comb begin
    sel_we_s    = we0;
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    if (pick_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Access sequencer; every SRAM strobe and handshake output is a register
  always_ff @(posedge clk_sys or negedge rst_) begin
    if (!rst_) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      grant_r  <= 1'b0;
      wr_r     <= 1'b0;
      ram_ce   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_we   <= 1'b0;
      ram_doe  <= 1'b0;
      ram_a    <= '0;
      ram_dout <= 16'h0000;
      rdata    <= 16'h0000;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0 || req1) begin
            grant_r <= pick_s;
            wr_r    <= sel_we_s;
            ram_a   <= sel_addr_s;
            ram_ce  <= 1'b1;
            busy    <= 1'b1;
            if (sel_we_s) begin
              ram_doe  <= 1'b1;
              ram_dout <= sel_wdata_s;
            end else begin
              ram_oe <= 1'b1;
            end
            state_r <= SETUP;
          end
        end
        SETUP: begin
          // Write strobe only after a full cycle of address/data setup
          ram_we  <= wr_r;
          cnt_r   <= ACC_LAST;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
            if (!wr_r) begin
              rdata <= ram_din;
            end
            ack0    <= ~grant_r;
            ack1    <= grant_r;
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        HOLD: begin
          // ce and doe were kept through this cycle for data hold after the write edge
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          ram_ce  <= 1'b0;
          ram_doe <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ram_ce  <= 1'b0;
          ram_oe  <= 1'b0;
          ram_we  <= 1'b0;
          ram_doe <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized self-checking bench; three arbiters (ACCESS_CYCLES 2, 1, 15) each
// with a behavioural SRAM, checked against per-access timing windows and a memory scoreboard.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int ADDR_W = 18;

  logic clk_sys = 1'b0;
  logic rst_    = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic [2:0]             req0, we0, req1, we1;
  logic [2:0][ADDR_W-1:0] addr0, addr1;
  logic [2:0][15:0]       wdata0, wdata1;
  wire  [2:0]             ack0, ack1, busy, ram_ce, ram_oe, ram_we, ram_doe;
  wire  [2:0][15:0]       rdata, ram_dout, ram_din;
  wire  [2:0][ADDR_W-1:0] ram_a;

  int n_checks = 0;
  int n_fail   = 0;
  int last_served [3];
  logic [15:0] exp_mem [int];
  logic [ADDR_W-1:0] wq [$];

  logic [31:0] m_ack0, m_ack1, m_we, m_oe, m_ce, m_doe, m_busy;
  logic [15:0]       o_rdata [32];
  logic [ADDR_W-1:0] o_a     [32];
  logic [15:0]       o_dout  [32];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] mem [0:255];
    sram_arbiter #(.ACCESS_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15)), .ADDR_W(ADDR_W)) dut (
      .clk_sys(clk_sys), .rst_(rst_),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]), .ack1(ack1[g]),
      .rdata(rdata[g]), .busy(busy[g]), .ram_ce(ram_ce[g]), .ram_oe(ram_oe[g]),
      .ram_we(ram_we[g]), .ram_a(ram_a[g]), .ram_dout(ram_dout[g]), .ram_doe(ram_doe[g]),
      .ram_din(ram_din[g])
    );
    // Asynchronous SRAM: write lands on the trailing edge of we, read is combinational
    always @(negedge ram_we[g]) if (ram_ce[g]) mem[ram_a[g][7:0]] = ram_dout[g];
    assign ram_din[g] = (ram_ce[g] && ram_oe[g]) ? mem[ram_a[g][7:0]] : 16'hbad0;
  end

  function automatic int ac_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic int key(input int k, input logic [ADDR_W-1:0] a);
    return k * 1000000 + int'(a);
  endfunction

  function automatic logic [31:0] win(input int lo, input int hi);
    logic [31:0] m;
    m = 32'h0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic run_cycles(input int k, input int n, input bit drop_both);
    m_ack0 = 32'h0; m_ack1 = 32'h0; m_we = 32'h0; m_oe = 32'h0;
    m_ce = 32'h0; m_doe = 32'h0; m_busy = 32'h0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      m_ack0[i] = ack0[k]; m_ack1[i] = ack1[k]; m_we[i] = ram_we[k]; m_oe[i] = ram_oe[k];
      m_ce[i] = ram_ce[k]; m_doe[i] = ram_doe[k]; m_busy[i] = busy[k];
      o_rdata[i] = rdata[k]; o_a[i] = ram_a[k]; o_dout[i] = ram_dout[k];
      if (ack0[k] || (drop_both && ack1[k])) req0[k] = 1'b0;
      if (ack1[k] || (drop_both && ack0[k])) req1[k] = 1'b0;
    end
  endtask

  task automatic run_access(input int k, input int p, input bit w,
                            input logic [ADDR_W-1:0] a, input logic [15:0] d);
    int ac;
    int bad_a;
    int bad_d;
    logic [15:0] exp_rd;
    logic [31:0] e_ack;
    logic [63:0] e_acks;
    ac = ac_of(k);
    bad_a = 0;
    bad_d = 0;
    exp_rd = exp_mem.exists(key(k, a)) ? exp_mem[key(k, a)] : 16'h0000;
    if (p == 0) begin
      we0[k] = w; addr0[k] = a; wdata0[k] = d; req0[k] = 1'b1;
    end else begin
      we1[k] = w; addr1[k] = a; wdata1[k] = d; req1[k] = 1'b1;
    end
    run_cycles(k, ac + 3, 1'b0);
    e_ack  = win(ac + 2, ac + 2);
    e_acks = (p == 0) ? {32'h0, e_ack} : {e_ack, 32'h0};
    n_checks++;
    if ({m_ack1, m_ack0} !== e_acks) begin
      n_fail++; $display("FAIL ack_window k=%0d p=%0d: got %h expected %h", k, p, {m_ack1, m_ack0}, e_acks);
    end
    n_checks++;
    if (m_ce !== win(1, ac + 2)) begin
      n_fail++; $display("FAIL ce_window k=%0d: got %h expected %h", k, m_ce, win(1, ac + 2));
    end
    n_checks++;
    if (m_busy !== win(1, ac + 2)) begin
      n_fail++; $display("FAIL busy_window k=%0d: got %h expected %h", k, m_busy, win(1, ac + 2));
    end
    n_checks++;
    if (m_we !== (w ? win(2, ac + 1) : 32'h0)) begin
      n_fail++; $display("FAIL we_window k=%0d w=%0d: got %h expected %h", k, w, m_we, w ? win(2, ac + 1) : 32'h0);
    end
    n_checks++;
    if (m_oe !== (w ? 32'h0 : win(1, ac + 1))) begin
      n_fail++; $display("FAIL oe_window k=%0d w=%0d: got %h expected %h", k, w, m_oe, w ? 32'h0 : win(1, ac + 1));
    end
    n_checks++;
    if (m_doe !== (w ? win(1, ac + 2) : 32'h0)) begin
      n_fail++; $display("FAIL doe_window k=%0d w=%0d: got %h expected %h", k, w, m_doe, w ? win(1, ac + 2) : 32'h0);
    end
    for (int i = 1; i <= ac + 3; i++) begin
      if (o_a[i] !== a) bad_a++;
      if (w && (i <= ac + 2) && (o_dout[i] !== d)) bad_d++;
    end
    n_checks++;
    if (bad_a != 0) begin
      n_fail++; $display("FAIL ram_a k=%0d: %0d cycles differ from required %h", k, bad_a, a);
    end
    if (w) begin
      n_checks++;
      if (bad_d != 0) begin
        n_fail++; $display("FAIL ram_dout k=%0d: %0d cycles differ from required %h", k, bad_d, d);
      end
      exp_mem[key(k, a)] = d;
    end else begin
      n_checks++;
      if (o_rdata[ac + 2] !== exp_rd) begin
        n_fail++; $display("FAIL rdata_at_ack k=%0d: got %h expected %h", k, o_rdata[ac + 2], exp_rd);
      end
      n_checks++;
      if (o_rdata[ac + 3] !== exp_rd) begin
        n_fail++; $display("FAIL rdata_held k=%0d: got %h expected %h", k, o_rdata[ac + 3], exp_rd);
      end
    end
    last_served[k] = p;
  endtask

  task automatic test_reset();
    req0 = 3'b000; req1 = 3'b000; we0 = 3'b000; we1 = 3'b000;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_ = 1'b0;
    repeat (3) @(negedge clk_sys);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({busy[k], ram_ce[k], ram_oe[k], ram_we[k], ram_doe[k], ack0[k], ack1[k]} !== 7'b0 ||
          ram_a[k] !== '0 || rdata[k] !== 16'h0000 || ram_dout[k] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_state k=%0d: ctl=%b a=%h rdata=%h dout=%h expected all zero", k,
          {busy[k], ram_ce[k], ram_oe[k], ram_we[k], ram_doe[k], ack0[k], ack1[k]}, ram_a[k], rdata[k], ram_dout[k]);
      end
      last_served[k] = 1;
    end
    rst_ = 1'b1;
    run_cycles(0, 2, 1'b0);
    n_checks++;
    if ((m_busy | m_ce | m_ack0 | m_ack1) !== 32'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected 0", m_busy | m_ce | m_ack0 | m_ack1);
    end
  endtask

  task automatic test_write_read();
    run_access(0, 0, 1'b1, 18'h00010, 16'h1234);
    run_access(0, 1, 1'b0, 18'h00010, 16'h0000);
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (rdata[0] !== 16'h1234) begin
      n_fail++; $display("FAIL rdata_idle_hold: got %h expected 1234", rdata[0]);
    end
  endtask

  task automatic test_arbitration();
    int ac;
    int exp_p;
    logic [ADDR_W-1:0] a0, a1;
    logic [15:0] d0, d1;
    ac = ac_of(0);
    for (int r = 0; r < 3; r++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_p = (last_served[0] == 1) ? 0 : 1;
`else
      exp_p = 0;
`endif
      a0 = ADDR_W'($urandom_range(32, 79));
      a1 = ADDR_W'($urandom_range(80, 127));
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      we0[0] = 1'b1; addr0[0] = a0; wdata0[0] = d0;
      we1[0] = 1'b1; addr1[0] = a1; wdata1[0] = d1;
      req0[0] = 1'b1; req1[0] = 1'b1;
      run_cycles(0, ac + 3, 1'b1);
      n_checks++;
      if ({m_ack1, m_ack0} !== ((exp_p == 0) ? {32'h0, win(ac + 2, ac + 2)} : {win(ac + 2, ac + 2), 32'h0})) begin
        n_fail++; $display("FAIL arb_grant round=%0d: ack1/ack0 got %h/%h expected port %0d", r, m_ack1, m_ack0, exp_p);
      end
      n_checks++;
      if (o_a[1] !== ((exp_p == 0) ? a0 : a1) || o_dout[1] !== ((exp_p == 0) ? d0 : d1)) begin
        n_fail++; $display("FAIL arb_fields round=%0d: got a=%h d=%h expected port %0d fields", r, o_a[1], o_dout[1], exp_p);
      end
      exp_mem[key(0, (exp_p == 0) ? a0 : a1)] = (exp_p == 0) ? d0 : d1;
      last_served[0] = exp_p;
    end
  endtask

  task automatic test_no_preempt();
    int ac;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    ac = ac_of(0);
    a = ADDR_W'($urandom_range(32, 127));
    d = 16'($urandom);
    we0[0] = 1'b1; addr0[0] = a; wdata0[0] = d; req0[0] = 1'b1;
    run_cycles(0, 2, 1'b0);
    exp_mem[key(0, a)] = d;
    we1[0] = 1'b0; addr1[0] = a; req1[0] = 1'b1;
    run_cycles(0, 2 * ac + 4, 1'b0);
    n_checks++;
    if (m_ack0 !== win(ac, ac) || m_ack1 !== win(2 * ac + 3, 2 * ac + 3)) begin
      n_fail++; $display("FAIL no_preempt_acks: ack0=%h ack1=%h expected %h %h", m_ack0, m_ack1,
        win(ac, ac), win(2 * ac + 3, 2 * ac + 3));
    end
    n_checks++;
    if (m_we !== win(1, ac - 1)) begin
      n_fail++; $display("FAIL no_preempt_we: got %h expected %h", m_we, win(1, ac - 1));
    end
    n_checks++;
    if (o_rdata[2 * ac + 3] !== d) begin
      n_fail++; $display("FAIL no_preempt_rdata: got %h expected %h", o_rdata[2 * ac + 3], d);
    end
    last_served[0] = 1;
  endtask

  task automatic test_back_to_back();
    int p;
    bit w;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    for (int n = 0; n < 12; n++) begin
      p = int'($urandom_range(0, 1));
      w = (wq.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (w) begin
        a = ADDR_W'($urandom_range(32, 127));
        wq.push_back(a);
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
      end
      run_access(0, p, w, a, d);
    end
  endtask

  task automatic test_widths();
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    for (int k = 1; k < 3; k++) begin
      a = ADDR_W'($urandom_range(32, 127));
      d = 16'($urandom);
      run_access(k, 0, 1'b1, a, d);
      run_access(k, 1, 1'b0, a, d);
    end
  endtask

  task automatic test_reset_abort();
    we0[0] = 1'b1; addr0[0] = 18'h000F0; wdata0[0] = 16'hA5A5; req0[0] = 1'b1;
    run_cycles(0, 2, 1'b0);
    n_checks++;
    if (ram_we[0] !== 1'b1) begin
      n_fail++; $display("FAIL abort_precondition_we: got %b expected 1", ram_we[0]);
    end
    #1 rst_ = 1'b0;
    #1;
    n_checks++;
    if ({ram_we[0], ram_ce[0], ram_doe[0], ram_oe[0], busy[0], ack0[0], ack1[0]} !== 7'b0) begin
      n_fail++; $display("FAIL abort_async_drop: got %b expected 0000000",
        {ram_we[0], ram_ce[0], ram_doe[0], ram_oe[0], busy[0], ack0[0], ack1[0]});
    end
    req0[0] = 1'b0;
    we0[0]  = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_ = 1'b1;
    for (int k = 0; k < 3; k++) last_served[k] = 1;
    run_cycles(0, 5, 1'b0);
    n_checks++;
    if ((m_ack0 | m_ack1 | m_busy | m_ce) !== 32'h0) begin
      n_fail++; $display("FAIL abort_no_ack: got %h expected 0", m_ack0 | m_ack1 | m_busy | m_ce);
    end
    run_access(0, 1, 1'b0, 18'h00010, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_no_preempt();
    test_back_to_back();
    test_widths();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the external 16-bit asynchronous SRAM between two requesters:
  - port 0: the CPU memory interface;
  - port 1: a debug/loader engine behind the control-panel UART.
- Sequences the SRAM control strobes with programmable access timing.
- Sits between the requesters and the top-level SRAM pins.
- The top level inverts ce/oe/we to the active-low pins and builds the tristate from dout/doe.

Parameters:
ACCESS_CYCLES, 2, number of cycles the strobe (oe or we) is held active; legal range 1..15.
ADDR_W, 18, SRAM word-address width.

Ports:
clk_sys  in  1  system clock; all state updates on the rising edge.
rst_  in  1  asynchronous active-low reset.
req0  in  1  port 0 request level.
we0  in  1  port 0 write (1) / read (0).
addr0  in  ADDR_W  port 0 word address.
wdata0  in  16  port 0 write data.
ack0  out  1  port 0 completion pulse.
req1, we1, addr1, wdata1, ack1  (port 1, same directions, widths and meanings as port 0).
rdata  out  16  read data, shared by both ports; valid while the matching ack is high, then held.
busy  out  1  high in every state except IDLE.
ram_ce  out  1  SRAM chip enable, active high.
ram_oe  out  1  SRAM output enable, active high.
ram_we  out  1  SRAM write enable, active high.
ram_a  out  ADDR_W  SRAM address.
ram_dout  out  16  data driven to SRAM.
ram_doe  out  1  top-level tristate enable for ram_dout.
ram_din  in  16  data from the SRAM pins.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state = IDLE; all strobes, ram_doe, ack0/1 and busy = 0;
  - ram_a = 0, ram_dout = 0, rdata = 0; grant = port 0; last-served pointer = port 1.
- Reset asserted mid-access aborts the access immediately. Strobes drop asynchronously; no ack is issued.
- Request rules:
  - a requester holds req/we/addr/wdata stable until it sees its ack;
  - it must drop req in the cycle after ack;
  - req still high when the arbiter is back in IDLE counts as a new access.
- IDLE:
  - if any req is high on an edge, pick a winner (arbitration below);
  - latch its we/addr/wdata into internal registers; go to SETUP.
- SETUP (1 cycle):
  - ram_ce = 1 and ram_a = latched address;
  - write: ram_doe = 1 and ram_dout = wdata; ram_we stays 0 (address setup);
  - read: ram_oe = 1.
- ACCESS (ACCESS_CYCLES cycles, 4-bit down counter):
  - ce held; write asserts ram_we; read keeps ram_oe;
  - on the last cycle of a read, capture ram_din into rdata.
- HOLD (1 cycle):
  - ram_we = 0 and ram_oe = 0; ram_ce and ram_doe stay 1, giving data hold after the write edge;
  - the winner's ack = 1 for exactly this cycle; go to IDLE.
- Latency:
  - req sampled at edge N gives ack high in cycle N+2+ACCESS_CYCLES;
  - minimum back-to-back period = 3+ACCESS_CYCLES cycles per access, including the IDLE cycle.
- Arbitration (default):
  - fixed priority, port 0 wins simultaneous requests;
  - a request arriving during an access waits; no preemption.
- Address is never modified (no wrap/increment). ram_a holds its last value in IDLE.
- ack0 and ack1 are never high together; exactly one ack per granted access.

Optional Feature:
SRAM_ARB_ROUND_ROBIN_EN
- Defined:
  - on a simultaneous request, the port not served last wins;
  - the last-served pointer updates at the HOLD cycle;
  - a single requester is always served regardless of the pointer.
- Undefined: fixed priority to port 0 as above; the pointer register is not synthesized.

Test Plan:
- Reset release, ACCESS_CYCLES=2: port 0 writes 0x1234 to addr 0x00010. Required response:
  - SETUP: ce=1, doe=1, we=0;
  - ACCESS: we=1 for 2 cycles;
  - HOLD: we=0, ce=1, ack0=1;
  - ack0 high 4 cycles after the sampling edge.
- Port 1 reads addr 0x00010, SRAM model returns 0x1234. Required response:
  - oe=1 for 3 cycles, ack1 pulses once, rdata=0x1234;
  - rdata held after the ack.
- req0 and req1 asserted on the same edge, three times:
  - default build serves port 0 every time;
  - with SRAM_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0.
- req1 rises while a port 0 access is in ACCESS:
  - port 0 completes untouched;
  - port 1 starts from IDLE, giving ack1 3+ACCESS_CYCLES cycles after ack0.
- rst_ pulled low mid-write during ACCESS:
  - ram_we, ram_ce and ram_doe drop without waiting for a clock edge;
  - no ack issued; state = IDLE after release.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=15:
  - strobe width is exactly 1 and 15 cycles respectively;
  - busy is high from SETUP through HOLD.
